// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: state encoding, instruction opcodes, ALU ops,
// and the opcode classification / opcode-to-ALU-op lookups.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    // Execute-phase shape: two-operand ALU, HI/LO-producing, single-operand, or unknown.
    typedef enum logic [1:0] {
        CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_BAD
    } iclass_e;

    localparam logic [4:0] OPC_ADD = 5'b00011;
    localparam logic [4:0] OPC_SUB = 5'b00100;
    localparam logic [4:0] OPC_AND = 5'b00101;
    localparam logic [4:0] OPC_OR  = 5'b00110;
    localparam logic [4:0] OPC_MUL = 5'b01111;
    localparam logic [4:0] OPC_DIV = 5'b10000;
    localparam logic [4:0] OPC_NEG = 5'b10001;
    localparam logic [4:0] OPC_NOT = 5'b10010;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_NEG = 5'b00100;
    localparam logic [4:0] ALU_NOT = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    function automatic iclass_e opc_class(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: return CLS_ALU;
            OPC_MUL, OPC_DIV:                  return CLS_MULDIV;
            OPC_NEG, OPC_NOT:                  return CLS_UNARY;
            default:                           return CLS_BAD;
        endcase
    endfunction

    function automatic logic [4:0] opc_to_alu(input logic [4:0] opc);
        case (opc)
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            OPC_NEG: return ALU_NEG;
            OPC_NOT: return ALU_NOT;
            OPC_MUL: return ALU_MUL;
            OPC_DIV: return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot enable decoder; all-zero when not enabled.
module reg_select_decoder #(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic [REG_SEL_W-1:0] sel,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (sel == REG_SEL_W'(i));
        end
    end

endmodule

// File: rtl/mdu_instr_sequencer.sv
// Hard-wired fetch/execute sequencer for R-format ALU, MUL and DIV instructions.
// Outputs are decoded from the registered state and IR; T1 waits on MemReady.
module mdu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic [31:0]         IR,
    input  logic                MemReady,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                IRin,
    output logic                Yin,
    output logic                ZHighin,
    output logic                ZLowin,
    output logic                ZHighout,
    output logic                ZLowout,
    output logic                HIin,
    output logic                LOin,
    output logic [4:0]          OP,
    output logic                Busy,
    output logic                Done,
    output logic                Illegal
);

    state_e  state_q, state_d;
    iclass_e cls;
    logic [4:0]           opc;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic [REG_SEL_W-1:0] rin_sel, rout_sel;
    logic                 rin_en, rout_en;
    logic                 unused_ir;

    assign opc       = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];
    assign cls       = opc_class(opc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (MemReady) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (cls == CLS_BAD) ? S_HALT : S_T4;
            S_T4:   if (cls == CLS_UNARY) state_d = Run ? S_T0 : S_IDLE;
                    else                  state_d = S_T5;
            S_T5:   if (cls == CLS_ALU)   state_d = Run ? S_T0 : S_IDLE;
                    else                  state_d = S_T6;
            S_T6:   state_d = Run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0;
        ZHighin = 1'b0; ZLowin = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OP = ALU_ADD; Done = 1'b0;
        rin_en = 1'b0; rin_sel = ra; rout_en = 1'b0; rout_sel = rb;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1; end
            S_T1: begin ZLowout = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = MemReady; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (cls)
                CLS_ALU:    begin rout_en = 1'b1; Yin = 1'b1; end
                CLS_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
                CLS_UNARY:  begin rout_en = 1'b1; OP = opc_to_alu(opc); ZLowin = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                CLS_ALU:    begin rout_en = 1'b1; rout_sel = rc; OP = opc_to_alu(opc); ZLowin = 1'b1; end
                CLS_MULDIV: begin rout_en = 1'b1; OP = opc_to_alu(opc); ZHighin = 1'b1; ZLowin = 1'b1; end
                CLS_UNARY:  begin ZLowout = 1'b1; rin_en = 1'b1; Done = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                CLS_ALU:    begin ZLowout = 1'b1; rin_en = 1'b1; Done = 1'b1; end
                CLS_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; end
                default: ;
            endcase
            S_T6: begin ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1; end
            default: ;
        endcase
    end

    assign Busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign Illegal = (state_q == S_HALT);

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rin_dec (
        .sel(rin_sel), .en(rin_en), .onehot(Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rout_dec (
        .sel(rout_sel), .en(rout_en), .onehot(Rout)
    );

endmodule

// File: tb/tb_mdu_instr_sequencer.sv
// Cycle-by-cycle vector bench for mdu_instr_sequencer with an expected-value queue.
module tb_mdu_instr_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [14:0] f;
        logic [4:0]  op;
        logic        busy;
        logic        done;
        logic        ill;
    } ctl_t;

    typedef struct {
        string       name;
        logic        run;
        logic        mr;
        logic        clr;
        logic [31:0] ir;
        ctl_t        exp;
    } vec_t;

    localparam logic [14:0] F_PCOUT    = 15'h0001;
    localparam logic [14:0] F_PCIN     = 15'h0002;
    localparam logic [14:0] F_INCPC    = 15'h0004;
    localparam logic [14:0] F_MARIN    = 15'h0008;
    localparam logic [14:0] F_MDRIN    = 15'h0010;
    localparam logic [14:0] F_MDROUT   = 15'h0020;
    localparam logic [14:0] F_READ     = 15'h0040;
    localparam logic [14:0] F_IRIN     = 15'h0080;
    localparam logic [14:0] F_YIN      = 15'h0100;
    localparam logic [14:0] F_ZHIGHIN  = 15'h0200;
    localparam logic [14:0] F_ZLOWIN   = 15'h0400;
    localparam logic [14:0] F_ZHIGHOUT = 15'h0800;
    localparam logic [14:0] F_ZLOWOUT  = 15'h1000;
    localparam logic [14:0] F_HIIN     = 15'h2000;
    localparam logic [14:0] F_LOIN     = 15'h4000;

    localparam logic [31:0] IR_DIV = 32'h83380000;
    localparam logic [31:0] IR_ADD = 32'h18918000;
    localparam logic [31:0] IR_MUL = 32'h79180000;
    localparam logic [31:0] IR_ILL = 32'hF8000000;
    localparam logic [31:0] IR_NEG = {5'b10001, 4'd5, 4'd9, 4'd0, 15'd0};
    localparam logic [31:0] IR_SUB = {5'b00100, 4'd4, 4'd5, 4'd6, 15'd0};

    localparam int TIMEOUT_NS = 100000;

    logic        Clock, Clear, Run, MemReady;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
    logic ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin;
    logic [4:0] OP;
    logic Busy, Done, Illegal;

    mdu_instr_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemReady(MemReady),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .ZHighin(ZHighin), .ZLowin(ZLowin), .ZHighout(ZHighout),
        .ZLowout(ZLowout), .HIin(HIin), .LOin(LOin), .OP(OP), .Busy(Busy),
        .Done(Done), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int   tests_run = 0;
    int   tests_failed = 0;
    bit   sim_done = 1'b0;
    vec_t vecs[$];
    ctl_t exp_q[$];

    function automatic logic [15:0] oh(input int i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    function automatic ctl_t mk(input logic [15:0] rin, input logic [15:0] rout,
                                input logic [14:0] f, input logic [4:0] op,
                                input logic busy, input logic done, input logic ill);
        ctl_t c;
        c.rin = rin; c.rout = rout; c.f = f; c.op = op;
        c.busy = busy; c.done = done; c.ill = ill;
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.rin  = Rin;
        c.rout = Rout;
        c.f    = {LOin, HIin, ZLowout, ZHighout, ZLowin, ZHighin, Yin, IRin,
                  Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};
        c.op   = OP;
        c.busy = Busy;
        c.done = Done;
        c.ill  = Illegal;
        return c;
    endfunction

    task automatic add_v(input string name, input logic run, input logic mr,
                         input logic clr, input logic [31:0] ir, input ctl_t e);
        vec_t v;
        v.name = name; v.run = run; v.mr = mr; v.clr = clr; v.ir = ir; v.exp = e;
        vecs.push_back(v);
    endtask

    ctl_t e_idle, e_t0, e_t1w, e_t1r, e_t2;

    task automatic add_fetch(input string tag, input logic run, input logic [31:0] ir);
        add_v({tag, "_t0"}, run, 1'b1, 1'b0, ir, e_t0);
        add_v({tag, "_t1"}, run, 1'b1, 1'b0, ir, e_t1r);
        add_v({tag, "_t2"}, run, 1'b1, 1'b0, ir, e_t2);
    endtask

    initial begin
        #(TIMEOUT_NS);
        if (!sim_done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout: bench did not complete within %0d ns", TIMEOUT_NS);
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $finish;
        end
    end

    initial begin
        ctl_t got, exp;
        Clear = 1'b1; Run = 1'b0; MemReady = 1'b0; IR = '0;

        e_idle = mk(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        e_t0   = mk(16'h0, 16'h0, F_PCOUT | F_MARIN | F_INCPC | F_ZLOWIN, 5'd0, 1'b1, 1'b0, 1'b0);
        e_t1w  = mk(16'h0, 16'h0, F_ZLOWOUT | F_READ | F_MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
        e_t1r  = mk(16'h0, 16'h0, F_ZLOWOUT | F_READ | F_MDRIN | F_PCIN, 5'd0, 1'b1, 1'b0, 1'b0);
        e_t2   = mk(16'h0, 16'h0, F_MDROUT | F_IRIN, 5'd0, 1'b1, 1'b0, 1'b0);

        add_v("reset_idle",  1'b0, 1'b1, 1'b0, IR_DIV, e_idle);
        add_v("idle_hold",   1'b0, 1'b1, 1'b0, IR_DIV, e_idle);

        add_v("div_start",   1'b1, 1'b1, 1'b0, IR_DIV, e_idle);
        add_fetch("div", 1'b0, IR_DIV);
        add_v("div_t3", 1'b0, 1'b1, 1'b0, IR_DIV, mk(16'h0, oh(6), F_YIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("div_t4", 1'b0, 1'b1, 1'b0, IR_DIV, mk(16'h0, oh(7), F_ZHIGHIN | F_ZLOWIN, 5'b00111, 1'b1, 1'b0, 1'b0));
        add_v("div_t5", 1'b0, 1'b1, 1'b0, IR_DIV, mk(16'h0, 16'h0, F_ZLOWOUT | F_LOIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("div_t6", 1'b0, 1'b1, 1'b0, IR_DIV, mk(16'h0, 16'h0, F_ZHIGHOUT | F_HIIN, 5'd0, 1'b1, 1'b1, 1'b0));
        add_v("div_idle", 1'b0, 1'b1, 1'b0, IR_DIV, e_idle);

        add_v("add_start",   1'b1, 1'b1, 1'b0, IR_ADD, e_idle);
        add_fetch("add", 1'b0, IR_ADD);
        add_v("add_t3", 1'b0, 1'b1, 1'b0, IR_ADD, mk(16'h0, oh(2), F_YIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("add_t4", 1'b0, 1'b1, 1'b0, IR_ADD, mk(16'h0, oh(3), F_ZLOWIN, 5'b00000, 1'b1, 1'b0, 1'b0));
        add_v("add_t5", 1'b0, 1'b1, 1'b0, IR_ADD, mk(oh(1), 16'h0, F_ZLOWOUT, 5'd0, 1'b1, 1'b1, 1'b0));
        add_v("add_idle", 1'b0, 1'b1, 1'b0, IR_ADD, e_idle);

        add_v("mul_start",   1'b1, 1'b1, 1'b0, IR_MUL, e_idle);
        add_fetch("mul", 1'b1, IR_MUL);
        add_v("mul_t3", 1'b1, 1'b1, 1'b0, IR_MUL, mk(16'h0, oh(2), F_YIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("mul_t4", 1'b1, 1'b1, 1'b0, IR_MUL, mk(16'h0, oh(3), F_ZHIGHIN | F_ZLOWIN, 5'b00110, 1'b1, 1'b0, 1'b0));
        add_v("mul_t5", 1'b1, 1'b1, 1'b0, IR_MUL, mk(16'h0, 16'h0, F_ZLOWOUT | F_LOIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("mul_t6", 1'b1, 1'b1, 1'b0, IR_MUL, mk(16'h0, 16'h0, F_ZHIGHOUT | F_HIIN, 5'd0, 1'b1, 1'b1, 1'b0));
        add_v("b2b_t0",  1'b1, 1'b1, 1'b0, IR_MUL, e_t0);
        add_v("stall_1", 1'b1, 1'b0, 1'b0, IR_MUL, e_t1w);
        add_v("stall_2", 1'b1, 1'b0, 1'b0, IR_MUL, e_t1w);
        add_v("stall_3", 1'b1, 1'b0, 1'b0, IR_MUL, e_t1w);
        add_v("stall_rdy", 1'b1, 1'b1, 1'b0, IR_MUL, e_t1r);
        add_v("stall_t2", 1'b1, 1'b1, 1'b0, IR_SUB, e_t2);

        add_v("sub_t3", 1'b1, 1'b1, 1'b0, IR_SUB, mk(16'h0, oh(5), F_YIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("sub_t4", 1'b1, 1'b1, 1'b0, IR_SUB, mk(16'h0, oh(6), F_ZLOWIN, 5'b00001, 1'b1, 1'b0, 1'b0));
        add_v("sub_t5", 1'b0, 1'b1, 1'b0, IR_SUB, mk(oh(4), 16'h0, F_ZLOWOUT, 5'd0, 1'b1, 1'b1, 1'b0));
        add_v("sub_idle", 1'b0, 1'b1, 1'b0, IR_SUB, e_idle);

        add_v("neg_start", 1'b1, 1'b1, 1'b0, IR_NEG, e_idle);
        add_fetch("neg", 1'b0, IR_NEG);
        add_v("neg_t3", 1'b0, 1'b1, 1'b0, IR_NEG, mk(16'h0, oh(9), F_ZLOWIN, 5'b00100, 1'b1, 1'b0, 1'b0));
        add_v("neg_t4", 1'b0, 1'b1, 1'b0, IR_NEG, mk(oh(5), 16'h0, F_ZLOWOUT, 5'd0, 1'b1, 1'b1, 1'b0));
        add_v("neg_idle", 1'b0, 1'b1, 1'b0, IR_NEG, e_idle);

        add_v("ill_start", 1'b1, 1'b1, 1'b0, IR_ILL, e_idle);
        add_fetch("ill", 1'b0, IR_ILL);
        add_v("ill_t3",  1'b1, 1'b1, 1'b0, IR_ILL, mk(16'h0, 16'h0, 15'h0, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("halt_1",  1'b1, 1'b1, 1'b0, IR_ILL, mk(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        add_v("halt_2",  1'b1, 1'b1, 1'b0, IR_ADD, mk(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        add_v("halt_clr", 1'b1, 1'b1, 1'b1, IR_ADD, mk(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        add_v("halt_exit", 1'b0, 1'b1, 1'b0, IR_ADD, e_idle);

        add_v("abort_start", 1'b1, 1'b1, 1'b0, IR_DIV, e_idle);
        add_fetch("abort", 1'b0, IR_DIV);
        add_v("abort_t3", 1'b0, 1'b1, 1'b0, IR_DIV, mk(16'h0, oh(6), F_YIN, 5'd0, 1'b1, 1'b0, 1'b0));
        add_v("abort_t4", 1'b0, 1'b1, 1'b1, IR_DIV, mk(16'h0, oh(7), F_ZHIGHIN | F_ZLOWIN, 5'b00111, 1'b1, 1'b0, 1'b0));
        add_v("abort_idle1", 1'b0, 1'b1, 1'b0, IR_DIV, e_idle);
        add_v("abort_idle2", 1'b0, 1'b1, 1'b0, IR_DIV, e_idle);
        add_v("abort_idle3", 1'b0, 1'b1, 1'b0, IR_DIV, e_idle);

        repeat (2) @(posedge Clock);

        @(negedge Clock);
        #1;
        got = sample();
        tests_run++;
        if (got !== e_idle) begin
            tests_failed++;
            $display("FAIL reset_state: got rin=%h rout=%h f=%h op=%b busy=%b done=%b ill=%b, want all zero",
                     got.rin, got.rout, got.f, got.op, got.busy, got.done, got.ill);
        end

        foreach (vecs[k]) begin
            @(negedge Clock);
            Run      = vecs[k].run;
            MemReady = vecs[k].mr;
            Clear    = vecs[k].clr;
            IR       = vecs[k].ir;
            exp_q.push_back(vecs[k].exp);
            #1;
            got = sample();
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s: got rin=%h rout=%h f=%h op=%b busy=%b done=%b ill=%b, want rin=%h rout=%h f=%h op=%b busy=%b done=%b ill=%b",
                         vecs[k].name, got.rin, got.rout, got.f, got.op, got.busy, got.done, got.ill,
                         exp.rin, exp.rout, exp.f, exp.op, exp.busy, exp.done, exp.ill);
            end
        end

        sim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mdu_instr_sequencer.md
Name: mdu_instr_sequencer

Overview:
- Hard-wired control unit that sequences the datapath through fetch (T0–T2) and execute (T3–T6) for R-format ALU instructions, including MUL and DIV.
- Drives every datapath enable and select currently hand-driven by benches: Rin/Rout, PCout, MARin, MDRin, Read, Yin, Z/HI/LO, OP, and the rest.
- Sits between the datapath and the top-level Run/Done interface. Memory readiness is a handshake input.

Parameters:
- NUM_REGS, 16, number of general registers; sets the width of the one-hot Rin/Rout buses.
- REG_SEL_W, 4, width of the Ra/Rb/Rc fields in IR.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- Run  in  1  level; start or continue instruction execution.
- IR  in  32  instruction register contents from the datapath. Opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- MemReady  in  1  memory data valid on Mdatain this cycle.
- Rin  out  16  one-hot register load enables.
- Rout  out  16  one-hot register drive enables.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin  out  1 each  datapath controls.
- ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin  out  1 each  datapath controls.
- OP  out  5  ALU operation select.
- Busy  out  1  high in any state other than IDLE and HALT.
- Done  out  1  one-cycle pulse in the last execute cycle.
- Illegal  out  1  high while in HALT.

Behaviour:
- Clocking and reset: one clock, Clock. Clear is synchronous and active-high.
- Clear=1 at a rising edge puts the FSM in IDLE, from any state including mid-instruction. Whatever the state, all outputs are 0 while in IDLE.
- State register: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a Moore decode of the registered state plus IR; the only exceptions are the MemReady qualifier in T1 and the opcode qualifier in T3.
- Any control not listed for a state is 0.
- IDLE: Run=1 -> T0; otherwise stay.
- T0: PCout, MARin, IncPC, ZLowin. OP=ADD. -> T1.
- T1: ZLowout, Read, MDRin held high.
  - MemReady=0: stay in T1, PCin=0.
  - MemReady=1: PCin=1 this cycle, -> T2.
- T2: MDRout, IRin. -> T3.
- T3: decode IR[31:27].
  - Opcode not in the package table: no controls asserted, -> HALT.
  - ADD/SUB/AND/OR: Rout[Rb], Yin.
  - MUL/DIV: Rout[Ra], Yin.
  - NEG/NOT: Rout[Rb], OP=op, ZLowin.
  - All legal opcodes -> T4.
- T4:
  - ADD/SUB/AND/OR: Rout[Rc], OP=op, ZLowin.
  - MUL/DIV: Rout[Rb], OP=op, ZHighin, ZLowin.
  - NEG/NOT: ZLowout, Rin[Ra], Done. This is the last step.
- T5:
  - ADD/SUB/AND/OR: ZLowout, Rin[Ra], Done. This is the last step.
  - MUL/DIV: ZLowout, LOin.
- T6 (MUL/DIV only): ZHighout, HIin, Done.
- After the last step: Run=1 -> T0 (back-to-back instructions); Run=0 -> IDLE.
- HALT: Illegal=1. Exit only by Clear. Run is ignored.
- Rin/Rout: exactly one bit or no bits set. Index = the 4-bit field value.
- OP mapping (package): ADD 00000, SUB 00001, AND 00010, OR 00011, NEG 00100, NOT 00101, MUL 00110, DIV 00111.
- Instruction opcodes (package): ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- Latency, assuming no memory stall: ADD class 6 cycles T0–T5; MUL/DIV 7 cycles; NEG/NOT 5 cycles. Each MemReady=0 cycle in T1 adds 1.
- IR is sampled combinationally in T3–T6. The datapath holds IR stable until the next IRin.

Decomposition:
- Package cpu_ctrl_pkg: state encoding, instruction opcode constants, ALU OP constants, and the opcode-to-OP lookup function.
- Sub-module reg_select_decoder: 4-bit field plus enable -> 16-bit one-hot. Instantiated twice, once for Rin and once for Rout.

Test Plan:
- DIV R6,R7, IR=0x83380000, MemReady tied 1, Run pulsed for 1 cycle:
  - T3: Rout[6], Yin.
  - T4: Rout[7], OP=00111, ZHighin, ZLowin.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin, Done.
  - Then IDLE, Busy=0.
- ADD R1,R2,R3, IR=0x18918000:
  - T3: Rout[2], Yin.
  - T4: Rout[3], OP=00000, ZLowin.
  - T5: ZLowout, Rin[1], Done.
  - Exactly 6 cycles from T0.
- MUL R2,R3, IR=0x79180000, Run held high: Done in T6, and the next cycle is T0 with PCout, MARin, IncPC.
- MemReady low for 3 cycles in T1: Read and MDRin high for 4 cycles; PCin high only on the 4th cycle; T2 follows.
- Illegal opcode, IR=0xF8000000: T3 asserts nothing, then HALT with Illegal=1 and Busy=0. Run has no effect; Clear -> IDLE.
- Clear asserted during T4 of DIV: next cycle is IDLE with all outputs 0; no LOin or HIin are ever asserted.
